// File: rtl/squareroot_ahsqr_k6.sv
// Approximate hybrid integer square root (AHSQR), k = 6.
// 16-bit unsigned radicand in, 8-bit root out, one register stage.
// The root never exceeds floor(sqrt(R)). The upper five root bits are exact.
// The lower three bits are decided against R with its six LSBs dropped.

module squareroot_ahsqr_k6 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] R,
  output logic [7:0]  final_op
);

  // Radicand LSBs excluded from the trial comparisons (fixed for this block)
  localparam int unsigned K     = 6;
  localparam int unsigned RootW = 8;
  localparam int unsigned SqW   = 18;

  // Truncated radicand scaled back up: Rh * 64.
  // ceil(T*T / 64) <= Rh holds exactly when T*T <= Rh * 64, so every stage is
  // one plain compare against this value.
  logic [SqW-1:0]   rh_scaled;
  logic [RootW-1:0] root_d;
  logic [RootW-1:0] root_q;

  assign rh_scaled = {2'b00, R[15:K], {K{1'b0}}};

  // Digit-by-digit root array. The running square of the accepted partial root
  // is carried along, so each trial square is an incremental update:
  //   (P + 2^j)^2 = P^2 + P * 2^(j+1) + 2^(2j)
  // The largest trial square is 255^2 = 65025, so 18 bits cannot overflow.
  function automatic logic [RootW-1:0] ahsqr_root(input logic [SqW-1:0] limit);
    logic [RootW-1:0] p;
    logic [SqW-1:0]   sq;
    logic [SqW-1:0]   trial_sq;
    p  = '0;
    sq = '0;
    for (int j = RootW - 1; j >= 0; j--) begin
      trial_sq = sq + ({{(SqW - RootW){1'b0}}, p} << (j + 1)) + (18'd1 << (2 * j));
      if (trial_sq <= limit) begin
        sq = trial_sq;
        p  = p | (8'd1 << j);
      end
    end
    return p;
  endfunction

  // Next root value from the current radicand
  always_comb begin
    root_d = ahsqr_root(rh_scaled);
  end

  // Output register; asynchronous reset clears the root immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      root_q <= '0;
    end else begin
      root_q <= root_d;
    end
  end

  assign final_op = root_q;

endmodule

// File: tb/tb_squareroot_ahsqr_k6.sv
// Self-checking bench for squareroot_ahsqr_k6.
module tb_squareroot_ahsqr_k6;

  logic        clk;
  logic        rst_n;
  logic [15:0] R;
  logic [7:0]  final_op;

  int errors;
  int checks;

  squareroot_ahsqr_k6 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .R        (R),
    .final_op (final_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: greedy root selection using ceil(T*T/64) <= floor(R/64)
  function automatic int model_f(input int r);
    int p;
    int t;
    int rh;
    p  = 0;
    rh = r / 64;
    for (int j = 7; j >= 0; j--) begin
      t = p | (1 << j);
      if ((t * t + 63) / 64 <= rh) p = t;
    end
    return p;
  endfunction

  // Exact floor(sqrt(r))
  function automatic int isqrt(input int r);
    int s;
    s = 0;
    while ((s + 1) * (s + 1) <= r) s++;
    return s;
  endfunction

  // Apply a radicand and sample one edge later
  task automatic apply_and_wait(input logic [15:0] val);
    R = val;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    R     = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (final_op !== 8'd0) begin
      errors++;
      $display("FAIL reset_hold: got %0d expected 0", final_op);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (final_op !== 8'd255) begin
      errors++;
      $display("FAIL reset_release: got %0d expected 255", final_op);
    end
  endtask

  task automatic test_exact_points();
    logic [15:0] pts [6];
    logic [7:0]  exp_v [6];
    pts   = '{16'd0, 16'd64, 16'd4096, 16'd4200, 16'd16383, 16'd65535};
    exp_v = '{8'd0, 8'd8, 8'd64, 8'd64, 8'd127, 8'd255};
    for (int i = 0; i < 6; i++) begin
      apply_and_wait(pts[i]);
      checks++;
      if (final_op !== exp_v[i]) begin
        errors++;
        $display("FAIL exact_point R=%0d: got %0d expected %0d", pts[i], final_op, exp_v[i]);
      end
    end
  endtask

  task automatic test_approx_region();
    apply_and_wait(16'd63);
    checks++;
    if (final_op !== 8'd0) begin
      errors++;
      $display("FAIL approx R=63: got %0d expected 0", final_op);
    end
    apply_and_wait(16'd100);
    checks++;
    if (final_op !== 8'd8) begin
      errors++;
      $display("FAIL approx R=100: got %0d expected 8", final_op);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq [3];
    logic [7:0]  exp_v [3];
    seq   = '{16'd4096, 16'd65535, 16'd64};
    exp_v = '{8'd64, 8'd255, 8'd8};
    for (int i = 0; i < 3; i++) begin
      apply_and_wait(seq[i]);
      checks++;
      if (final_op !== exp_v[i]) begin
        errors++;
        $display("FAIL back_to_back step %0d: got %0d expected %0d", i, final_op, exp_v[i]);
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 65535);
      apply_and_wait(r[15:0]);
      checks++;
      if (final_op !== 8'(model_f(r))) begin
        errors++;
        $display("FAIL random R=%0d: got %0d expected %0d", r, final_op, model_f(r));
      end
    end
  endtask

  task automatic test_sweep();
    int   exact;
    int   ed;
    int   ed_max;
    int   n_err;
    int   prev;
    real  sum_abs;
    real  sum_rel;
    exact   = 0;
    ed_max  = 0;
    n_err   = 0;
    prev    = 0;
    sum_abs = 0.0;
    sum_rel = 0.0;
    for (int r = 0; r < 65536; r++) begin
      apply_and_wait(r[15:0]);
      while ((exact + 1) * (exact + 1) <= r) exact++;
      checks++;
      if (final_op !== 8'(model_f(r))) begin
        errors++;
        $display("FAIL sweep R=%0d: got %0d expected %0d", r, final_op, model_f(r));
      end
      checks++;
      if (int'(final_op) > exact) begin
        errors++;
        $display("FAIL overestimate R=%0d: got %0d limit %0d", r, final_op, exact);
      end
      checks++;
      if (int'(final_op) < prev) begin
        errors++;
        $display("FAIL monotonic R=%0d: got %0d previous %0d", r, final_op, prev);
      end
      prev = int'(final_op);
      ed   = exact - int'(final_op);
      if (ed < 0) ed = -ed;
      if (ed != 0) n_err++;
      if (ed > ed_max) ed_max = ed;
      sum_abs += real'(ed);
      if (r >= 1) sum_rel += real'(ed) / real'(exact);
    end
    checks++;
    if (ed_max != 7) begin
      errors++;
      $display("FAIL ed_max: got %0d expected 7", ed_max);
    end
    checks++;
    if (isqrt(65535) - 255 != 0 || ed_max < 0) begin
      errors++;
      $display("FAIL isqrt_reference: got %0d expected 255", isqrt(65535));
    end
    $display("sweep stats: ER=%f NMED=%e MRED=%e EDmax=%0d",
             real'(n_err) / 65536.0, sum_abs / (255.0 * 65536.0),
             sum_rel / 65535.0, ed_max);
  endtask

  task automatic test_async_reset();
    apply_and_wait(16'hFFFF);
    checks++;
    if (final_op !== 8'd255) begin
      errors++;
      $display("FAIL async_pre: got %0d expected 255", final_op);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (final_op !== 8'd0) begin
      errors++;
      $display("FAIL async_assert: got %0d expected 0", final_op);
    end
    @(posedge clk);
    #1;
    checks++;
    if (final_op !== 8'd0) begin
      errors++;
      $display("FAIL async_hold: got %0d expected 0", final_op);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (final_op !== 8'd255) begin
      errors++;
      $display("FAIL async_release: got %0d expected 255", final_op);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    R      = 16'd0;
    test_reset();
    test_exact_points();
    test_approx_region();
    test_back_to_back();
    test_random();
    test_sweep();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
